// File: rtl/iig_row_integrator.sv
// Row-at-a-time integral image of an 8-bit pixel stream. The previous row's
// integral values live in an external ping-pong line buffer (read one half, write the other).
module iig_row_integrator #(
  parameter int WIDTH  = 80,
  parameter int HEIGHT = 100,
  parameter int SUMW   = 21
) (
  input  logic            iClk,
  input  logic            iReset_n,
  input  logic            iStart,
  input  logic            iValid,
  input  logic [7:0]      iPixel,
  output logic            oReady,
  output logic            oValid,
  output logic [SUMW-1:0] oData,
  output logic            oFrameDone,
  output logic            oPPSelect,
  output logic            oPPRdreq,
  output logic            oPPWrreq,
  output logic [SUMW-1:0] oPPData,
  input  logic [SUMW-1:0] iPPData,
  input  logic            iPPEmpty,
  output logic            oError
);

  // state   | meaning
  // S_IDLE  | waiting for iStart; counters cleared on start
  // S_ROW   | accepting pixels of the current row
  // S_DRAIN | pipeline flush until the row's final write is issued
  // S_SWAP  | toggle ping-pong select, advance row or finish frame

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int RW  = $clog2(HEIGHT + 1);
  localparam int RSW = 15;
  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);
  localparam logic [1:0]    DRAIN_CYC = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_DRAIN, S_SWAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RSW-1:0]  rowsum_q, rowsum_d;
  logic [1:0]      drain_q, drain_d;
  logic            sel_q, sel_d;
  logic            err_q, err_d;
  logic            v1_q, v1_d;
  logic            rd1_q, rd1_d;
  logic            val_q, val_d;
  logic [SUMW-1:0] data_q, data_d;
  logic            wr_q, wr_d;
  logic            done_pend_q, done_pend_d;
  logic            done_q, done_d;
  logic            accept;
  logic            rdreq;
  logic            last_row;

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      rowsum_q    <= '0;
      drain_q     <= '0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
      v1_q        <= 1'b0;
      rd1_q       <= 1'b0;
      val_q       <= 1'b0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rowsum_q    <= rowsum_d;
      drain_q     <= drain_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      v1_q        <= v1_d;
      rd1_q       <= rd1_d;
      val_q       <= val_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    rowsum_d    = rowsum_q;
    drain_d     = drain_q;
    sel_d       = sel_q;
    done_pend_d = 1'b0;

    last_row = (row_q == LAST_ROW);
    accept   = iValid && (state_q == S_ROW);
    rdreq    = accept && (row_q != '0);

    // Stage 1 holds the updated rowsum; iPPData arrives alongside it.
    v1_d   = accept;
    rd1_d  = rdreq;
    val_d  = v1_q;
    data_d = data_q;
    if (v1_q) begin
      data_d = SUMW'(rowsum_q) + (rd1_q ? iPPData : '0);
    end
    wr_d   = v1_q && !last_row;
    err_d  = err_q || (rdreq && iPPEmpty);
    done_d = done_pend_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d  = S_ROW;
          col_d    = '0;
          row_d    = '0;
          rowsum_d = '0;
          err_d    = 1'b0;
        end
      end
      S_ROW: begin
        if (accept) begin
          rowsum_d = rowsum_q + RSW'(iPixel);
          col_d    = col_q + CW'(1);
          if (col_q == LAST_COL) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_CYC - 2'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_SWAP;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      S_SWAP: begin
        sel_d    = !sel_q;
        rowsum_d = '0;
        col_d    = '0;
        if (last_row) begin
          done_pend_d = 1'b1;
          row_d       = '0;
          state_d     = S_IDLE;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_ROW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oReady     = (state_q == S_ROW);
  assign oValid     = val_q;
  assign oData      = data_q;
  assign oFrameDone = done_q;
  assign oPPSelect  = sel_q;
  assign oPPRdreq   = rdreq;
  assign oPPWrreq   = wr_q;
  assign oPPData    = data_q;
  assign oError     = err_q;

endmodule

// File: tb/tb_iig_row_integrator.sv
// Bench for iig_row_integrator: a 4x3 instance and a default 80x100 instance, each
// backed by a ping-pong buffer model, checked against an integral-image scoreboard.
module tb_iig_row_integrator;

  logic        iClk;
  logic        rst_n;
  logic        start[2], valid[2], rdy[2], ov[2], fd[2], sel[2], rd[2], wr[2], err[2];
  logic        emp[2], force_e[2];
  logic [7:0]  pix[2];
  logic [20:0] od[2], wd[2], ppd[2];

  int n_chk, n_err, cyc;

  int m_prev[2][80];
  int m_r[2], m_c[2], m_rs[2];
  int fa[2], la[2];
  int sbd0[$], sbc0[$], sbd1[$], sbc1[$];

  int mem[2][2][80];
  int wp[2][2], rp[2][2];

  int vcnt[2], lastd[2], lastv[2], wrc[2], rdc[2], fdc[2], fdcyc[2], tg[2];
  logic psel[2];
  int row0last;

  iig_row_integrator #(.WIDTH(4), .HEIGHT(3), .SUMW(21)) u_small (
    .iClk(iClk), .iReset_n(rst_n), .iStart(start[0]), .iValid(valid[0]), .iPixel(pix[0]),
    .oReady(rdy[0]), .oValid(ov[0]), .oData(od[0]), .oFrameDone(fd[0]), .oPPSelect(sel[0]),
    .oPPRdreq(rd[0]), .oPPWrreq(wr[0]), .oPPData(wd[0]), .iPPData(ppd[0]),
    .iPPEmpty(emp[0]), .oError(err[0]));

  iig_row_integrator u_big (
    .iClk(iClk), .iReset_n(rst_n), .iStart(start[1]), .iValid(valid[1]), .iPixel(pix[1]),
    .oReady(rdy[1]), .oValid(ov[1]), .oData(od[1]), .oFrameDone(fd[1]), .oPPSelect(sel[1]),
    .oPPRdreq(rd[1]), .oPPWrreq(wr[1]), .oPPData(wd[1]), .iPPData(ppd[1]),
    .iPPEmpty(emp[1]), .oError(err[1]));

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ping-pong buffer model: writes go to half [sel], reads come from half [!sel].
  always @(posedge iClk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int b = 0; b < 2; b++) begin
          wp[i][b] = 0;
          rp[i][b] = 0;
        end
        ppd[i] <= '0;
      end else begin
        int rb, wb;
        rb = sel[i] ? 0 : 1;
        wb = sel[i] ? 1 : 0;
        if (rd[i] && rp[i][rb] < wp[i][rb]) begin
          ppd[i] <= 21'(mem[i][rb][rp[i][rb]]);
          rp[i][rb]++;
          if (rp[i][rb] == wp[i][rb]) begin
            rp[i][rb] = 0;
            wp[i][rb] = 0;
          end
        end
        if (wr[i] && wp[i][wb] < 80) begin
          mem[i][wb][wp[i][wb]] = int'(wd[i]);
          wp[i][wb]++;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      emp[i] = 1'b0;
      emp[i] = force_e[i] | (sel[i] ? (rp[i][0] >= wp[i][0]) : (rp[i][1] >= wp[i][1]));
    end
  end

  // Output monitor and scoreboard
  always @(negedge iClk) begin
    for (int i = 0; i < 2; i++) begin
      int d, c;
      bit have;
      if (ov[i]) begin
        vcnt[i]++;
        lastd[i] = int'(od[i]);
        lastv[i] = cyc;
        if (i == 1 && vcnt[1] == 80) row0last = int'(od[1]);
        have = 1'b0;
        d = 0;
        c = 0;
        if (i == 0 && sbd0.size() > 0) begin
          d = sbd0.pop_front(); c = sbc0.pop_front(); have = 1'b1;
        end else if (i == 1 && sbd1.size() > 0) begin
          d = sbd1.pop_front(); c = sbc1.pop_front(); have = 1'b1;
        end
        if (!have) begin
          chk("unexpected_ovalid", 1, 0);
        end else begin
          chk(i == 0 ? "s_data" : "b_data", od[i], d);
          chk(i == 0 ? "s_latency" : "b_latency", cyc, c);
          if (wr[i]) chk("ppdata", wd[i], d);
        end
      end
      if (wr[i]) wrc[i]++;
      if (rd[i]) rdc[i]++;
      if (fd[i]) begin
        fdc[i]++;
        fdcyc[i] = cyc;
      end
      if (sel[i] !== psel[i]) tg[i]++;
      psel[i] = sel[i];
    end
  end

  task automatic start_frame(input int i);
    m_r[i] = 0;
    m_c[i] = 0;
    m_rs[i] = 0;
    fa[i] = -1;
    start[i] = 1'b1;
    @(negedge iClk);
    start[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] p);
    int n, w, h, e;
    w = (i == 0) ? 4 : 80;
    h = (i == 0) ? 3 : 100;
    valid[i] = 1'b1;
    pix[i] = p;
    n = 0;
    while (!rdy[i] && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!rdy[i]) begin
      chk("accept_timeout", 0, 1);
    end else begin
      m_rs[i] += int'(p);
      e = m_rs[i] + ((m_r[i] > 0) ? m_prev[i][m_c[i]] : 0);
      m_prev[i][m_c[i]] = e;
      if (i == 0) begin
        sbd0.push_back(e); sbc0.push_back(cyc + 2);
      end else begin
        sbd1.push_back(e); sbc1.push_back(cyc + 2);
      end
      if (fa[i] < 0) fa[i] = cyc;
      la[i] = cyc;
      m_c[i]++;
      if (m_c[i] == w) begin
        m_c[i] = 0;
        m_rs[i] = 0;
        m_r[i] = (m_r[i] == h - 1) ? 0 : m_r[i] + 1;
      end
    end
    @(negedge iClk);
    valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int f0, n;
    f0 = fdc[i];
    n = 0;
    while (fdc[i] == f0 && n < 2000) begin
      @(negedge iClk);
      #1;
      n++;
    end
    chk("frame_done_seen", (fdc[i] != f0), 1);
    @(negedge iClk);
    #1;
  endtask

  initial begin
    int wr0, rd0, tg0, fd0, v0;
    n_chk = 0; n_err = 0; cyc = 0; row0last = 0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; valid[i] = 0; pix[i] = 0; force_e[i] = 0; psel[i] = 0;
      vcnt[i] = 0; lastd[i] = 0; lastv[i] = 0; wrc[i] = 0; rdc[i] = 0;
      fdc[i] = 0; fdcyc[i] = 0; tg[i] = 0; fa[i] = -1; la[i] = 0;
    end

    // Reset with random inputs
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = 1'($urandom_range(0, 1));
        valid[i] = 1'($urandom_range(0, 1));
        pix[i]   = 8'($urandom_range(0, 255));
      end
      @(negedge iClk);
      #1;
      for (int i = 0; i < 2; i++)
        chk("reset_outputs", {rdy[i], ov[i], od[i], fd[i], sel[i], rd[i], wr[i], wd[i], err[i]}, 0);
    end
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; valid[i] = 0; pix[i] = 0;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge iClk);
    #1;
    chk("idle_ready_s", rdy[0], 0);
    chk("idle_ready_b", rdy[1], 0);

    // Small frame, all ones, continuous
    wr0 = wrc[0]; rd0 = rdc[0]; tg0 = tg[0]; fd0 = fdc[0];
    start_frame(0);
    for (int k = 0; k < 12; k++) send(0, 8'd1);
    wait_done(0);
    chk("ones_wr_count", wrc[0] - wr0, 8);
    chk("ones_rd_count", rdc[0] - rd0, 8);
    chk("ones_sel_toggles", tg[0] - tg0, 3);
    chk("ones_done_count", fdc[0] - fd0, 1);
    chk("ones_done_after_valid", fdcyc[0] - lastv[0], 3);
    chk("ones_accept_span", la[0] - fa[0], 17);
    chk("ones_last_value", lastd[0], 12);
    chk("ones_error", err[0], 0);

    // Forced empty during row 1
    start_frame(0);
    for (int k = 0; k < 4; k++) send(0, 8'd2);
    chk("err_before_read", err[0], 0);
    force_e[0] = 1'b1;
    send(0, 8'd2);
    #1;
    chk("err_on_first_read", err[0], 1);
    force_e[0] = 1'b0;
    for (int k = 0; k < 7; k++) send(0, 8'd2);
    wait_done(0);
    chk("err_sticky", err[0], 1);

    // Frame A: iStart clears error, then reset mid-row 1
    start_frame(0);
    #1;
    chk("err_cleared_by_start", err[0], 0);
    for (int k = 0; k < 6; k++) send(0, 8'd7);
    #1;
    chk("sel_before_reset", sel[0], 1);
    rst_n = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    #1;
    sbd0.delete(); sbc0.delete();
    rst_n = 1'b1;
    #1;
    chk("sel_after_reset", sel[0], 0);
    chk("ready_after_reset", rdy[0], 0);
    chk("valid_after_reset", ov[0], 0);

    // Frame B: ramp pixels
    start_frame(0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) send(0, 8'(c));
    wait_done(0);
    chk("ramp_last_value", lastd[0], 18);
    chk("ramp_error", err[0], 0);

    // Gaps: iValid 1,0,1,1,0 over 5,7,9; mid-frame iStart ignored
    start_frame(0);
    v0 = vcnt[0];
    send(0, 8'd5);
    @(negedge iClk);
    send(0, 8'd7);
    send(0, 8'd9);
    repeat (3) @(negedge iClk);
    #1;
    chk("gap_valid_count", vcnt[0] - v0, 3);
    chk("gap_last_value", lastd[0], 21);
    start[0] = 1'b1;
    @(negedge iClk);
    start[0] = 1'b0;
    for (int k = 0; k < 9; k++) send(0, 8'd3);
    wait_done(0);
    chk("gap_frame_values", vcnt[0] - v0, 12);

    // Default-size frame, all 255
    fd0 = fdc[1];
    start_frame(1);
    for (int k = 0; k < 8000; k++) send(1, 8'd255);
    wait_done(1);
    chk("big_row0_last", row0last, 20400);
    chk("big_final", lastd[1], 2040000);
    chk("big_done_count", fdc[1] - fd0, 1);
    chk("big_error", err[1], 0);

    chk("sb_small_empty", sbd0.size(), 0);
    chk("sb_big_empty", sbd1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
